// File: rtl/calculator_keypad_pkg.sv
// Shared key codes, operator encodings and FSM state types for the calculator input path.
package calculator_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} scan_state_t;
  typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW} entry_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'h9);
  endfunction

  function automatic logic is_op_key(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // A..D map onto 00..11 by flipping bit 1 of the low two code bits.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    return k[1:0] ^ 2'b10;
  endfunction

endpackage

// File: rtl/calculator_keypad_scan.sv
// Row scanner and press/release debouncer for a 4x4 active-low matrix keypad.
module keypad_scan
  import calculator_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  scan_state_t      state;
  logic [1:0]       col_idx;
  logic [DB_W-1:0]  stable;
  logic [DB_W-1:0]  stable_next;

  // Lowest-index zero bit; used for both the sensed column and the driven row.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign tick        = (tick_cnt == CNT_LAST);
  assign stable_next = stable + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // stable doubles as the release counter while in PRESSED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      key_row   <= 4'b1110;
      col_idx   <= 2'd0;
      stable    <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (key_col == 4'hF) begin
              key_row <= {key_row[2:0], key_row[3]};
            end else begin
              col_idx <= low_idx(key_col);
              if (DEBOUNCE_SCANS <= 1) begin
                key_valid <= 1'b1;
                key_code  <= {low_idx(key_row), low_idx(key_col)};
                stable    <= '0;
                state     <= PRESSED;
              end else begin
                stable <= DB_W'(1);
                state  <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!key_col[col_idx]) begin
              if (stable_next >= DB_LAST) begin
                key_valid <= 1'b1;
                key_code  <= {low_idx(key_row), col_idx};
                stable    <= '0;
                state     <= PRESSED;
              end else begin
                stable <= stable_next;
              end
            end else begin
              state <= SCAN;
            end
          end
          PRESSED: begin
            if (key_col == 4'hF) begin
              if (stable_next >= DB_LAST) state <= SCAN;
              else                        stable <= stable_next;
            end else begin
              stable <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: rtl/calculator_keypad.sv
// Calculator input end: keypad scanning plus operand/operator entry and display selection.
module calculator_keypad
  import calculator_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_col,
  input  logic [31:0] cal_result,
  output logic [3:0]  key_row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  op,
  output logic        calc_go,
  output logic [31:0] disp_value
);

  entry_state_t state;
  logic [3:0]   digit_cnt;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // digit_cnt is shared: it counts digits of whichever operand is being typed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ENTER_A;
      operand_a <= 32'h0;
      operand_b <= 32'h0;
      op        <= OP_ADD;
      digit_cnt <= 4'd0;
      calc_go   <= 1'b0;
    end else begin
      calc_go <= 1'b0;
      if (key_valid) begin
        if (key_code == KEY_CLR) begin
          operand_a <= 32'h0;
          operand_b <= 32'h0;
          op        <= OP_ADD;
          digit_cnt <= 4'd0;
          state     <= ENTER_A;
        end else begin
          case (state)
            ENTER_A: begin
              if (is_digit(key_code)) begin
                if (digit_cnt < 4'd8) begin
                  operand_a <= {operand_a[27:0], key_code};
                  digit_cnt <= digit_cnt + 4'd1;
                end
              end else if (is_op_key(key_code)) begin
                op        <= key_to_op(key_code);
                operand_b <= 32'h0;
                digit_cnt <= 4'd0;
                state     <= ENTER_B;
              end
            end
            ENTER_B: begin
              if (is_digit(key_code)) begin
                if (digit_cnt < 4'd8) begin
                  operand_b <= {operand_b[27:0], key_code};
                  digit_cnt <= digit_cnt + 4'd1;
                end
              end else if (is_op_key(key_code)) begin
                op <= key_to_op(key_code);
              end else begin
                calc_go <= 1'b1;
                state   <= SHOW;
              end
            end
            SHOW: begin
              if (is_digit(key_code)) begin
                operand_a <= {28'h0, key_code};
                operand_b <= 32'h0;
                digit_cnt <= 4'd1;
                state     <= ENTER_A;
              end else if (is_op_key(key_code)) begin
                operand_a <= cal_result;
                op        <= key_to_op(key_code);
                operand_b <= 32'h0;
                digit_cnt <= 4'd0;
                state     <= ENTER_B;
              end else begin
                calc_go <= 1'b1;
              end
            end
            default: state <= ENTER_A;
          endcase
        end
      end
    end
  end

  always_comb begin
    disp_value = operand_a;
    case (state)
      ENTER_B: disp_value = operand_b;
      SHOW:    disp_value = cal_result;
      default: disp_value = operand_a;
    endcase
  end

endmodule

// File: tb/tb_calculator_keypad.sv
// Self-checking bench: physical keypad model drives the scanner; a calculator-level model predicts entry results.
module tb_calculator_keypad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_col;
  logic [31:0] cal_result = 32'h0;
  logic [3:0]  key_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  op;
  logic        calc_go;
  logic [31:0] disp_value;

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int cg_count = 0;

  // Physical keypad: a held key pulls its column low only while its row is driven.
  logic       pressed = 1'b0;
  logic [1:0] prow = 2'd0;
  logic [1:0] pcol = 2'd0;
  assign key_col = (pressed && (key_row[prow] == 1'b0)) ? ~(4'b0001 << pcol) : 4'hF;

  // Calculator-level reference state: 0 typing A, 1 typing B, 2 showing result.
  logic [31:0] m_a, m_b;
  logic [1:0]  m_op;
  int          m_st, m_cnt;

  calculator_keypad #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_col    (key_col),
    .cal_result (cal_result),
    .key_row    (key_row),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op         (op),
    .calc_go    (calc_go),
    .disp_value (disp_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_count++;
    if (calc_go === 1'b1) cg_count++;
  end

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_st = 0; m_cnt = 0;
  endtask

  task automatic model_key(input logic [3:0] k, output bit go);
    go = 0;
    if (k == 4'hE) begin
      m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_st = 0;
    end else if (k <= 4'h9) begin
      if (m_st == 2) begin
        m_a = 32'(k); m_b = 0; m_cnt = 1; m_st = 0;
      end else if (m_cnt < 8) begin
        if (m_st == 0) m_a = m_a * 16 + 32'(k);
        else           m_b = m_b * 16 + 32'(k);
        m_cnt++;
      end
    end else if (k <= 4'hD) begin
      m_op = 2'(k - 4'hA);
      if (m_st == 2) m_a = cal_result;
      if (m_st != 1) begin m_b = 0; m_cnt = 0; end
      m_st = 1;
    end else begin
      if (m_st != 0) begin go = 1; m_st = 2; end
    end
  endtask

  function automatic logic [31:0] m_disp();
    if (m_st == 0) return m_a;
    if (m_st == 1) return m_b;
    return cal_result;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press_key(input logic [3:0] k, input int hold);
    int kv0, cg0;
    bit got, go;
    kv0 = kv_count; cg0 = cg_count; got = 0; go = 0;
    prow = k[3:2]; pcol = k[1:0]; pressed = 1'b1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL press_timeout key=%h got no key_valid", k);
    end else begin
      checks++;
      if (key_code !== k) begin errors++; $display("FAIL key_code got=%h exp=%h", key_code, k); end
      model_key(k, go);
      @(negedge clk);
      checks++;
      if (operand_a !== m_a) begin errors++; $display("FAIL operand_a key=%h got=%h exp=%h", k, operand_a, m_a); end
      checks++;
      if (operand_b !== m_b) begin errors++; $display("FAIL operand_b key=%h got=%h exp=%h", k, operand_b, m_b); end
      checks++;
      if (op !== m_op) begin errors++; $display("FAIL op key=%h got=%b exp=%b", k, op, m_op); end
      checks++;
      if (disp_value !== m_disp()) begin errors++; $display("FAIL disp_value key=%h got=%h exp=%h", k, disp_value, m_disp()); end
      checks++;
      if (calc_go !== go) begin errors++; $display("FAIL calc_go key=%h got=%b exp=%b", k, calc_go, go); end
    end
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (kv_count - kv0 != 1) begin errors++; $display("FAIL key_valid_count key=%h got=%0d exp=1", k, kv_count - kv0); end
    checks++;
    if (cg_count - cg0 != int'(go)) begin errors++; $display("FAIL calc_go_count key=%h got=%0d exp=%0d", k, cg_count - cg0, int'(go)); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key_row !== 4'b1110) begin errors++; $display("FAIL rst_key_row got=%b exp=1110", key_row); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code got=%h exp=0", key_code); end
    checks++; if (operand_a !== 32'h0) begin errors++; $display("FAIL rst_operand_a got=%h exp=0", operand_a); end
    checks++; if (operand_b !== 32'h0) begin errors++; $display("FAIL rst_operand_b got=%h exp=0", operand_b); end
    checks++; if (op !== 2'b00) begin errors++; $display("FAIL rst_op got=%b exp=00", op); end
    checks++; if (calc_go !== 1'b0) begin errors++; $display("FAIL rst_calc_go got=%b exp=0", calc_go); end
    checks++; if (disp_value !== 32'h0) begin errors++; $display("FAIL rst_disp got=%h exp=0", disp_value); end
  endtask

  task automatic test_scan_idle();
    int kv0;
    logic [3:0] exp_row;
    do_reset();
    kv0 = kv_count;
    // Row advances on every 4th edge after reset release.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (((i + 1) / 4) % 4));
      checks++;
      if (key_row !== exp_row) begin errors++; $display("FAIL scan_row cyc=%0d got=%b exp=%b", i, key_row, exp_row); end
    end
    checks++;
    if (kv_count != kv0) begin errors++; $display("FAIL scan_idle_valid got=%0d exp=0", kv_count - kv0); end
  endtask

  task automatic test_single_press();
    do_reset();
    press_key(4'h6, 24);
    checks++;
    if (operand_a !== 32'h6) begin errors++; $display("FAIL single_operand_a got=%h exp=6", operand_a); end
  endtask

  task automatic test_bounce();
    int kv0;
    bit go;
    do_reset();
    kv0 = kv_count;
    prow = 2'd0; pcol = 2'd3; pressed = 1'b1;
    repeat (4) @(negedge clk);
    pressed = 1'b0;
    repeat (4) @(negedge clk);
    pressed = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (kv_count != kv0) begin errors++; $display("FAIL bounce_early got=%0d exp=0", kv_count - kv0); end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_valid got=%b exp=1", key_valid); end
    checks++;
    if (key_code !== 4'h3) begin errors++; $display("FAIL bounce_code got=%h exp=3", key_code); end
    model_key(4'h3, go);
    @(negedge clk);
    checks++;
    if (operand_a !== m_a) begin errors++; $display("FAIL bounce_operand_a got=%h exp=%h", operand_a, m_a); end
    repeat (4) @(negedge clk);
    pressed = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (kv_count - kv0 != 1) begin errors++; $display("FAIL bounce_count got=%0d exp=1", kv_count - kv0); end
  endtask

  task automatic test_calc_sequence();
    do_reset();
    cal_result = 32'h15;
    press_key(4'h1, 4);
    press_key(4'h2, 4);
    checks++; if (disp_value !== 32'h12) begin errors++; $display("FAIL seq_disp_a got=%h exp=12", disp_value); end
    press_key(4'hA, 4);
    press_key(4'h3, 4);
    checks++; if (disp_value !== 32'h3) begin errors++; $display("FAIL seq_disp_b got=%h exp=3", disp_value); end
    press_key(4'hF, 4);
    checks++; if (operand_a !== 32'h12) begin errors++; $display("FAIL seq_operand_a got=%h exp=12", operand_a); end
    checks++; if (operand_b !== 32'h3) begin errors++; $display("FAIL seq_operand_b got=%h exp=3", operand_b); end
    checks++; if (op !== 2'b00) begin errors++; $display("FAIL seq_op got=%b exp=00", op); end
    checks++; if (disp_value !== 32'h15) begin errors++; $display("FAIL seq_disp_res got=%h exp=15", disp_value); end
  endtask

  task automatic test_chain();
    press_key(4'hB, 4);
    press_key(4'h4, 4);
    press_key(4'hF, 4);
    checks++; if (operand_a !== 32'h15) begin errors++; $display("FAIL chain_operand_a got=%h exp=15", operand_a); end
    checks++; if (op !== 2'b01) begin errors++; $display("FAIL chain_op got=%b exp=01", op); end
    checks++; if (operand_b !== 32'h4) begin errors++; $display("FAIL chain_operand_b got=%h exp=4", operand_b); end
  endtask

  task automatic test_digit_limit();
    press_key(4'hE, 2);
    for (int d = 1; d <= 9; d++) press_key(4'(d), 2);
    checks++; if (operand_a !== 32'h12345678) begin errors++; $display("FAIL limit_operand_a got=%h exp=12345678", operand_a); end
    press_key(4'hE, 2);
    checks++; if (operand_a !== 32'h0) begin errors++; $display("FAIL clear_operand_a got=%h exp=0", operand_a); end
    checks++; if (operand_b !== 32'h0) begin errors++; $display("FAIL clear_operand_b got=%h exp=0", operand_b); end
    checks++; if (op !== 2'b00) begin errors++; $display("FAIL clear_op got=%b exp=00", op); end
    press_key(4'h5, 2);
    checks++; if (disp_value !== 32'h5) begin errors++; $display("FAIL clear_enter_a got=%h exp=5", disp_value); end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] k;
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 80) k = 4'($urandom_range(10, 13));
      else if (r < 93) k = 4'hF;
      else             k = 4'hE;
      cal_result = $urandom;
      press_key(k, $urandom_range(0, 12));
    end
  endtask

  task automatic test_reset_mid_debounce();
    int kv0;
    do_reset();
    kv0 = kv_count;
    prow = 2'd0; pcol = 2'd1; pressed = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (key_row !== 4'b1110) begin errors++; $display("FAIL middb_key_row got=%b exp=1110", key_row); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL middb_key_valid got=%b exp=0", key_valid); end
    rst_n = 1'b1;
    repeat (64) @(negedge clk);
    checks++;
    if (kv_count != kv0) begin errors++; $display("FAIL middb_count got=%0d exp=0", kv_count - kv0); end
    checks++; if (operand_a !== 32'h0) begin errors++; $display("FAIL middb_operand_a got=%h exp=0", operand_a); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_idle();
    test_single_press();
    test_bounce();
    test_calc_sequence();
    test_chain();
    test_digit_limit();
    test_random();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator_keypad.md
Name: calculator_keypad

Overview:
- Input end of the calculator: scans a 4x4 active-low matrix keypad, debounces it, and decodes key presses.
- Assembles two 32-bit hex operands and an operator, nibble by nibble. Nibble order matches the display's 4-bit digit format.
- Issues a one-cycle calc_go strobe to the ALU/display path.
- Drives disp_value so the display shows the current entry.

Parameters:
SCAN_DIV, 20000, clk cycles per scan tick (row dwell time)
DEBOUNCE_SCANS, 4, consecutive stable scan ticks to accept a press or a release

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
key_col  input  4  keypad column sense, active-low, pulled up externally
cal_result  input  32  result from ALU; source of operand_a when chaining after '='
key_row  output  4  row drive, one-hot active-low
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  code of last accepted key, 4*row+col
operand_a  output  32  first operand, hex nibbles, LSN = last digit typed
operand_b  output  32  second operand
op  output  2  00 add, 01 sub, 10 mul, 11 div
calc_go  output  1  one-cycle pulse requesting calculation
disp_value  output  32  value for display: operand_a, operand_b or cal_result, by entry state

Behaviour:
- Reset, synchronous (rst_n low at a clk edge), dominates everything, including a press mid-debounce:
  - key_row=4'b1110; key_valid=0, key_code=0, operand_a=0, operand_b=0, op=00, calc_go=0.
  - Scan FSM=SCAN; entry FSM=ENTER_A; tick counter=0.
- Scan tick: a free-running counter 0..SCAN_DIV-1 produces tick=1 for one cycle at SCAN_DIV-1. key_col is sampled only on tick.
- Scan FSM:
  - SCAN: on tick, if key_col==4'hF, rotate key_row left (1110->1101->1011->0111->1110). Otherwise hold the row, latch col = lowest index with key_col low, set stable=1, go DEBOUNCE.
  - DEBOUNCE: on tick, if the same col bit is still low, stable++. Else go SCAN with no pulse and the row resumes rotating. When stable reaches DEBOUNCE_SCANS, in that cycle: key_valid=1, key_code={row_idx,col_idx}, go PRESSED.
  - PRESSED: row held. On tick, key_col==4'hF increments the release count; any low bit clears it. When the count reaches DEBOUNCE_SCANS, go SCAN. Exactly one key_valid per physical press; other keys pressed while held are ignored.
- Key map: 0x0-0x9 digit; 0xA add; 0xB sub; 0xC mul; 0xD div; 0xE clear; 0xF equals.
- Entry FSM: acts in the cycle after key_valid (latency 1 clk from key_valid).
  - ENTER_A:
    - digit: operand_a <= {operand_a[27:0],digit}, only if digit_cnt<8; the 9th and later digits are ignored.
    - operator: op latched, operand_b=0, digit_cnt=0, go ENTER_B.
    - equals: ignored.
  - ENTER_B:
    - digit: shifts into operand_b, same 8-digit limit.
    - operator: replaces op.
    - equals: calc_go=1 for one cycle, go SHOW.
  - SHOW:
    - digit: operand_a={28'b0,digit}, operand_b=0, digit_cnt=1, go ENTER_A.
    - operator: operand_a<=cal_result, op latched, operand_b=0, go ENTER_B.
    - equals: calc_go pulses again; operands are unchanged.
  - clear (any state): operand_a=0, operand_b=0, op=00, digit_cnt=0, go ENTER_A. No calc_go.
- disp_value is combinational from registers: ENTER_A->operand_a, ENTER_B->operand_b, SHOW->cal_result.
- Width rules: digit_cnt is 4-bit and saturates at 8. Shifting drops no bits before the 8-digit limit.

Decomposition:
- Package calculator_pkg holds:
  - key code constants (KEY_ADD=4'hA ... KEY_EQ=4'hF);
  - op encodings;
  - scan-state enum SCAN/DEBOUNCE/PRESSED;
  - entry-state enum ENTER_A/ENTER_B/SHOW.
- Sub-module keypad_scan contains the tick counter, row rotation and debounce, and outputs key_valid/key_code.
- calculator_keypad instantiates it and implements the entry FSM.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
- Reset, then no keys for 16 ticks -> key_row cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts.
- Hold row1/col2 low for 6 ticks, then release for 3 ticks -> exactly one key_valid, key_code=4'h6, operand_a=32'h6.
- Bounce: col low for 1 tick, high 1 tick, then stable low 3 ticks -> one key_valid only after the stable window; no pulse from the glitch.
- Keys 1,2,A,3,F -> operand_a=32'h12, op=00, operand_b=32'h3; calc_go pulses one cycle; disp_value tracks 12->3->cal_result.
- Nine digits 1..9 -> operand_a=32'h12345678 (9 ignored). Then E -> all operands 0, state ENTER_A.
- After SHOW with cal_result=32'h15, key B then 4, F -> operand_a=32'h15, op=01, operand_b=32'h4, calc_go pulse. Assert rst_n=0 mid-debounce of a key -> no key_valid after reset, key_row=1110.
